// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch stage: datapath width,
// the canonical NOP, the default boot address and the fetch buffer entry layout.
package if_fetch_unit_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch stage bus: instruction memory request/response, EX redirect,
// hazard stall and the IF/ID slot presented to decode.
interface if_fetch_unit_if;
   import if_fetch_unit_pkg::*;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic [XLEN-1:0] imem_instr_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            stall_i;
   logic            if_id_valid_o;
   logic [XLEN-1:0] if_id_pc_o;
   logic [XLEN-1:0] if_id_pc_plus4_o;
   logic [XLEN-1:0] if_id_instr_o;

   modport master (
      output imem_req_o, imem_addr_o,
      output if_id_valid_o, if_id_pc_o, if_id_pc_plus4_o, if_id_instr_o,
      input  imem_instr_i, redirect_i, redirect_pc_i, stall_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o,
      input  if_id_valid_o, if_id_pc_o, if_id_pc_plus4_o, if_id_instr_o,
      output imem_instr_i, redirect_i, redirect_pc_i, stall_i
   );

endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small power-of-two FIFO with synchronous clear; clear also reloads every
// slot with CLR_VAL so an empty FIFO presents a known head.
module fetch_fifo #(
   parameter  int               DEPTH   = 2,
   parameter  int               WIDTH   = 64,
   parameter  logic [WIDTH-1:0] CLR_VAL = '0,
   localparam int               AW      = $clog2(DEPTH),
   localparam int               CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [AW-1:0]               rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]               count_q;
   logic                        full;

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (clr) begin
         mem_q    <= {DEPTH{CLR_VAL}};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // The request throttle upstream must never let a response land in a full buffer.
   a_no_push_full: assert property (@(posedge clk) disable iff (clr) !(push && full));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, single-cycle imem requests and a
// small {pc, instr} buffer whose head is the IF/ID slot.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   if_fetch_unit_if.master  bus
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [XLEN-1:0] pc_q, req_pc_q;
   logic            inflight_q, drop_q;
   logic [CW-1:0]   count;
   logic [CW:0]     occ;
   logic            empty, valid, pop, push, req, clr;
   fetch_entry_t    head, resp;

   assign valid = ~empty & ~bus.redirect_i & ~rst_i;
   assign pop   = valid & ~bus.stall_i;
   assign push  = inflight_q & ~drop_q & ~bus.redirect_i & ~rst_i;
   assign clr   = rst_i | bus.redirect_i;

   // Occupancy once this cycle's pop and the outstanding response settle.
   assign occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign req = ~rst_i & ~bus.redirect_i & ~(drop_q & inflight_q)
              & (occ < (CW+1)'(FIFO_DEPTH));

   assign resp = '{pc: req_pc_q, instr: bus.imem_instr_i};

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .WIDTH   ($bits(fetch_entry_t)),
      .CLR_VAL ({word_align(RESET_PC), NOP_INSTR})
   ) u_fifo (
      .clk   (clk_i),
      .clr   (clr),
      .push  (push),
      .wdata (resp),
      .pop   (pop),
      .rdata (head),
      .count (count),
      .empty (empty)
   );

   assign bus.imem_req_o       = req;
   assign bus.imem_addr_o      = pc_q;
   assign bus.if_id_valid_o    = valid;
   assign bus.if_id_pc_o       = rst_i ? word_align(RESET_PC) : head.pc;
   assign bus.if_id_pc_plus4_o = bus.if_id_pc_o + 32'd4;
   assign bus.if_id_instr_o    = valid ? head.instr : NOP_INSTR;

   // drop_q covers the single response slot after a redirect, then retires.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= word_align(RESET_PC);
         req_pc_q   <= word_align(RESET_PC);
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
      end else if (bus.redirect_i) begin
         pc_q       <= word_align(bus.redirect_pc_i);
         inflight_q <= 1'b0;
         drop_q     <= inflight_q;
      end else begin
         drop_q     <= 1'b0;
         inflight_q <= req;
         if (req) begin
            pc_q     <= pc_q + 32'd4;
            req_pc_q <= pc_q;
         end
      end
   end

endmodule
